// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: instruction-memory request/response plus the
// decode-side valid/ready stream. master = fetch stage, slave = environment.
interface instr_fetch_if;
    logic [31:0] instr_addr;
    logic        instr_REn;
    logic        instr_WEn;
    logic        I_valid;
    logic        I_clr;
    logic [31:0] R_instr;
    logic        I_err;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    modport master (
        output instr_addr, instr_REn, instr_WEn, I_valid, I_clr,
        output dec_valid, dec_instr, dec_pc,
        input  R_instr, I_err, dec_ready
    );

    modport slave (
        input  instr_addr, instr_REn, instr_WEn, I_valid, I_clr,
        input  dec_valid, dec_instr, dec_pc,
        output R_instr, I_err, dec_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, one-word memory requests, a small
// decode-side FIFO of {instr, pc}, branch redirect with flush, sticky faults.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0100_0000,
    parameter logic [31:0] IM_BASE    = 32'h0100_0000,
    parameter int unsigned IM_WORDS   = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_if.master        bus,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [31:0]          fault_pc
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_RANGE    = 2'b10;
    localparam logic [1:0] CODE_MEM_ERR  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t            state_q, state_n;
    logic [31:0]       pc_q, pc_n;
    logic [31:0]       addr_q, addr_n;
    logic              req_q, req_n;
    logic              rsp_q, rsp_n;
    logic [31:0]       rsp_pc_q, rsp_pc_n;
    logic [PTR_W-1:0]  rd_q, rd_n;
    logic [PTR_W-1:0]  wr_q, wr_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              head_valid_q, head_valid_n;
    logic [31:0]       head_instr_q, head_instr_n;
    logic [31:0]       head_pc_q, head_pc_n;
    logic              fault_q, fault_n;
    logic [1:0]        code_q, code_n;
    logic [31:0]       fpc_q, fpc_n;

    logic [31:0]       fifo_instr [FIFO_DEPTH];
    logic [31:0]       fifo_pc    [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic              rsp_live;
    logic              rsp_err;
    logic              pending;
    logic              space;
    logic [31:0]       pc_chk;

    // Next-state: redirect/flush, response handling, FIFO pointers, issue decision, head lookahead.
    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        addr_n   = addr_q;
        req_n    = 1'b0;
        rsp_pc_n = addr_q;
        rd_n     = rd_q;
        wr_n     = wr_q;
        count_n  = count_q;
        fault_n  = fault_q;
        code_n   = code_q;
        fpc_n    = fpc_q;
        pc_chk   = pc_q;
        pending  = 1'b0;

        pop      = head_valid_q && bus.dec_ready;
        rsp_live = rsp_q && !redirect_valid;
        rsp_err  = rsp_live && bus.I_err;
        push     = rsp_live && !bus.I_err;

        if (redirect_valid) begin
            // Flush everything; the request currently on the bus is squashed too.
            state_n = RUN;
            pc_chk  = redirect_pc;
            rd_n    = '0;
            wr_n    = '0;
            count_n = '0;
            fault_n = 1'b0;
            code_n  = '0;
            fpc_n   = '0;
        end else begin
            if (push) begin
                wr_n = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_n = rd_q + PTR_W'(1);
            end
            count_n = count_q + CNT_W'(push) - CNT_W'(pop);
            // A memory error also kills the younger request already on the bus.
            pending = req_q && !rsp_err;
            if (rsp_err) begin
                state_n = FAULT;
                fault_n = 1'b1;
                code_n  = CODE_MEM_ERR;
                fpc_n   = rsp_pc_q;
            end
        end

        pc_n  = pc_chk;
        space = (32'(count_n) + 32'(pending)) < FIFO_DEPTH;

        if ((state_n == RUN) && space) begin
            if (pc_chk[1:0] != 2'b00) begin
                state_n = FAULT;
                fault_n = 1'b1;
                code_n  = CODE_MISALIGN;
                fpc_n   = pc_chk;
            end else if ((pc_chk < IM_BASE) || ({1'b0, pc_chk} >= IM_END)) begin
                state_n = FAULT;
                fault_n = 1'b1;
                code_n  = CODE_RANGE;
                fpc_n   = pc_chk;
            end else begin
                req_n  = 1'b1;
                addr_n = pc_chk;
                pc_n   = pc_chk + 32'd4;
            end
        end

        rsp_n = pending;

        // Head register tracks the post-edge FIFO head, bypassing a push into an empty FIFO.
        head_valid_n = (count_n != '0);
        if (push && (wr_q == rd_n)) begin
            head_instr_n = bus.R_instr;
            head_pc_n    = rsp_pc_q;
        end else begin
            head_instr_n = fifo_instr[rd_n];
            head_pc_n    = fifo_pc[rd_n];
        end
        if (redirect_valid) begin
            head_instr_n = '0;
            head_pc_n    = '0;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            rsp_q        <= 1'b0;
            rsp_pc_q     <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            fault_q      <= 1'b0;
            code_q       <= '0;
            fpc_q        <= '0;
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            addr_q       <= addr_n;
            req_q        <= req_n;
            rsp_q        <= rsp_n;
            rsp_pc_q     <= rsp_pc_n;
            rd_q         <= rd_n;
            wr_q         <= wr_n;
            count_q      <= count_n;
            head_valid_q <= head_valid_n;
            head_instr_q <= head_instr_n;
            head_pc_q    <= head_pc_n;
            fault_q      <= fault_n;
            code_q       <= code_n;
            fpc_q        <= fpc_n;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_q] <= bus.R_instr;
            fifo_pc[wr_q]    <= rsp_pc_q;
        end
    end

    assign bus.instr_addr = addr_q;
    assign bus.I_valid    = req_q;
    assign bus.instr_REn  = req_q;
    assign bus.instr_WEn  = 1'b0;
    assign bus.I_clr      = 1'b0;
    assign bus.dec_valid  = head_valid_q;
    assign bus.dec_instr  = head_instr_q;
    assign bus.dec_pc     = head_pc_q;
    assign fault          = fault_q;
    assign fault_code     = code_q;
    assign fault_pc       = fpc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural instruction memory, expected
// {pc, instr} queue filled as stimulus is driven and drained as decode accepts.
module tb_instr_fetch;

    localparam logic [31:0] IM_BASE = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_pc;
    logic        err_en;
    logic [31:0] err_addr;

    int total = 0;
    int bad   = 0;
    ent_t exp_q[$];

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_code     (fault_code),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - IM_BASE) >> 2;
        if (idx < 32'd3) begin
            return (idx + 32'd1) * 32'h1111_1111;
        end
        return a ^ 32'h5A00_00A5;
    endfunction

    // Instruction memory: data and error valid the cycle after a request.
    always @(posedge clk) begin
        if (bus.I_valid) begin
            bus.R_instr <= mem_word(bus.instr_addr);
            bus.I_err   <= err_en && (bus.instr_addr == err_addr);
        end else begin
            bus.I_err   <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic pop_compare();
        ent_t e;
        e = exp_q.pop_front();
        check("dec_pc", bus.dec_pc, e.pc);
        check("dec_instr", bus.dec_instr, e.instr);
    endtask

    // Compare each accepted head against the queue; bounded by a cycle budget.
    task automatic collect(input int n, input int budget);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while ((got < n) && (cyc < budget)) begin
            if (bus.dec_valid && bus.dec_ready && (exp_q.size() > 0)) begin
                pop_compare();
                got++;
            end
            if (got < n) begin
                step();
                cyc++;
            end
        end
        check("collect_count", 32'(got), 32'(n));
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int n_req;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        err_en         = 1'b0;
        err_addr       = '0;
        bus.dec_ready  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", bus.instr_addr, 32'h0100_0000);
        check("rst_ivalid", bus.I_valid, 1'b0);
        check("rst_ren", bus.instr_REn, 1'b0);
        check("rst_wen", bus.instr_WEn, 1'b0);
        check("rst_clr", bus.I_clr, 1'b0);
        check("rst_dvalid", bus.dec_valid, 1'b0);
        check("rst_dinstr", bus.dec_instr, 32'h0);
        check("rst_dpc", bus.dec_pc, 32'h0);
        check("rst_fault", fault, 1'b0);
        check("rst_code", fault_code, 2'b00);
        check("rst_fpc", fault_pc, 32'h0);

        // Reset release: request from cycle 1, first instructions from cycle 3
        @(negedge clk);
        rst_n         = 1'b1;
        bus.dec_ready = 1'b1;
        step();
        check("c1_ivalid", bus.I_valid, 1'b1);
        check("c1_ren", bus.instr_REn, 1'b1);
        check("c1_addr", bus.instr_addr, 32'h0100_0000);
        step();
        check("c2_dvalid", bus.dec_valid, 1'b0);
        check("c2_ivalid", bus.I_valid, 1'b1);
        check("c2_addr", bus.instr_addr, 32'h0100_0004);
        step();
        expect_seq(32'h0100_0000, 3);
        for (int i = 0; i < 3; i++) begin
            check("stream_dvalid", bus.dec_valid, 1'b1);
            pop_compare();
            step();
        end

        // Backpressure: exactly FIFO_DEPTH requests, then in-order drain
        bus.dec_ready = 1'b0;
        do_redirect(32'h0100_0000);
        check("bp_first_addr", bus.instr_addr, 32'h0100_0000);
        check("bp_flush", bus.dec_valid, 1'b0);
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.I_valid) n_req++;
            step();
        end
        check("bp_req_count", 32'(n_req), 32'd4);
        check("bp_ivalid_off", bus.I_valid, 1'b0);
        check("bp_head_valid", bus.dec_valid, 1'b1);
        check("bp_head_pc", bus.dec_pc, 32'h0100_0000);
        check("bp_head_instr", bus.dec_instr, 32'h1111_1111);
        bus.dec_ready = 1'b1;
        exp_q.delete();
        expect_seq(32'h0100_0000, 8);
        collect(8, 40);

        // Redirect with two buffered entries and a response in flight
        bus.dec_ready = 1'b0;
        do_redirect(32'h0100_0000);
        repeat (3) step();
        check("rd_pre_dvalid", bus.dec_valid, 1'b1);
        check("rd_pre_dpc", bus.dec_pc, 32'h0100_0000);
        check("rd_pre_ivalid", bus.I_valid, 1'b1);
        do_redirect(32'h0100_0100);
        check("rd_flush", bus.dec_valid, 1'b0);
        check("rd_new_ivalid", bus.I_valid, 1'b1);
        check("rd_new_addr", bus.instr_addr, 32'h0100_0100);
        bus.dec_ready = 1'b1;
        exp_q.delete();
        expect_seq(32'h0100_0100, 3);
        collect(3, 20);

        // Misaligned redirect target
        do_redirect(32'h0100_0102);
        check("mis_fault", fault, 1'b1);
        check("mis_code", fault_code, 2'b01);
        check("mis_fpc", fault_pc, 32'h0100_0102);
        check("mis_ivalid", bus.I_valid, 1'b0);
        repeat (3) step();
        check("mis_ivalid_hold", bus.I_valid, 1'b0);
        check("mis_fault_hold", fault, 1'b1);

        // Sequential fetch runs off the end of instruction memory
        exp_q.delete();
        do_redirect(32'h0100_0FF0);
        check("rng_fault_clr", fault, 1'b0);
        check("rng_ivalid", bus.I_valid, 1'b1);
        expect_seq(32'h0100_0FF0, 4);
        collect(4, 20);
        repeat (3) step();
        check("rng_fault", fault, 1'b1);
        check("rng_code", fault_code, 2'b10);
        check("rng_fpc", fault_pc, 32'h0100_1000);
        check("rng_ivalid", bus.I_valid, 1'b0);
        check("rng_dvalid", bus.dec_valid, 1'b0);

        // Memory error on the third fetch
        err_en   = 1'b1;
        err_addr = 32'h0100_0008;
        exp_q.delete();
        expect_seq(32'h0100_0000, 2);
        do_redirect(32'h0100_0000);
        collect(2, 20);
        repeat (4) step();
        check("err_fault", fault, 1'b1);
        check("err_code", fault_code, 2'b11);
        check("err_fpc", fault_pc, 32'h0100_0008);
        check("err_dvalid", bus.dec_valid, 1'b0);
        check("err_ivalid", bus.I_valid, 1'b0);
        err_en = 1'b0;
        do_redirect(32'h0100_0000);
        check("err_clr_fault", fault, 1'b0);
        check("err_clr_code", fault_code, 2'b00);
        check("err_clr_fpc", fault_pc, 32'h0);
        check("err_resume_addr", bus.instr_addr, 32'h0100_0000);
        exp_q.delete();
        expect_seq(32'h0100_0000, 3);
        collect(3, 20);

        // Asynchronous reset in the middle of a stream
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ivalid", bus.I_valid, 1'b0);
        check("arst_ren", bus.instr_REn, 1'b0);
        check("arst_addr", bus.instr_addr, 32'h0100_0000);
        check("arst_dvalid", bus.dec_valid, 1'b0);
        check("arst_dinstr", bus.dec_instr, 32'h0);
        check("arst_dpc", bus.dec_pc, 32'h0);
        check("arst_fault", fault, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_restart_ivalid", bus.I_valid, 1'b1);
        check("arst_restart_addr", bus.instr_addr, 32'h0100_0000);
        exp_q.delete();
        expect_seq(32'h0100_0000, 3);
        collect(3, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
